// File: rtl/led_blink_code_sequencer.sv
// Blinks a 4-bit status code on an active-low LED: CODE pulses, then a long dark gap.
// Optional feature macro: BLINK_ABORT_EN adds an ABORT input that returns the sequencer to IDLE.
module led_blink_code_sequencer #(
  parameter int UNIT_CYCLES = 208000,
  parameter int ON_UNITS    = 2,
  parameter int OFF_UNITS   = 3,
  parameter int GAP_UNITS   = 10
) (
  input  logic       CLK,
  input  logic       RST,
`ifdef BLINK_ABORT_EN
  input  logic       ABORT,
`endif
  input  logic [3:0] CODE,
  input  logic       START,
  input  logic       REPEAT,
  output logic       BUSY,
  output logic       DONE,
  output logic       LEDn
);

  localparam int TW   = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam int MAXU = (ON_UNITS > OFF_UNITS) ?
                        ((ON_UNITS > GAP_UNITS) ? ON_UNITS : GAP_UNITS) :
                        ((OFF_UNITS > GAP_UNITS) ? OFF_UNITS : GAP_UNITS);
  localparam int UW   = (MAXU > 1) ? $clog2(MAXU + 1) : 1;

  localparam logic [TW-1:0] TMR_LAST = TW'(UNIT_CYCLES - 1);
  localparam logic [UW-1:0] ON_LAST  = UW'(ON_UNITS - 1);
  localparam logic [UW-1:0] OFF_LAST = UW'(OFF_UNITS - 1);
  localparam logic [UW-1:0] GAP_LAST = UW'(GAP_UNITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [UW-1:0] ucnt_q, ucnt_d;
  logic [3:0]    rem_q, rem_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abort_w;
  logic          unit_end;
  logic          phase_end;
  logic [UW-1:0] last_unit;

`ifdef BLINK_ABORT_EN
  assign abort_w = ABORT;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    ucnt_d    = ucnt_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    last_unit = GAP_LAST;

    case (state_q)
      S_ON:    last_unit = ON_LAST;
      S_OFF:   last_unit = OFF_LAST;
      default: last_unit = GAP_LAST;
    endcase

    unit_end  = (tmr_q == TMR_LAST);
    phase_end = unit_end && (ucnt_q == last_unit);

    if (state_q != S_IDLE) begin
      if (unit_end) begin
        tmr_d  = '0;
        ucnt_d = ucnt_q + 1'b1;
      end else begin
        tmr_d  = tmr_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (START && !abort_w) begin
          if (CODE != 4'd0) begin
            rem_d   = CODE;
            state_d = S_ON;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      S_ON: begin
        if (phase_end) begin
          rem_d   = rem_q - 4'd1;
          state_d = (rem_q > 4'd1) ? S_OFF : S_GAP;
        end
      end
      S_OFF: begin
        if (phase_end) state_d = S_ON;
      end
      default: begin
        if (phase_end) begin
          done_d = 1'b1;
          if (REPEAT && (CODE != 4'd0)) begin
            rem_d   = CODE;
            state_d = S_ON;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase

    if (abort_w && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end

    // Every state entry restarts timing, so each phase lasts exactly its unit count.
    if (state_d != state_q) begin
      tmr_d  = '0;
      ucnt_d = '0;
    end

    led_d  = (state_d != S_ON);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      ucnt_q  <= '0;
      rem_q   <= '0;
      led_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ucnt_q  <= ucnt_d;
      rem_q   <= rem_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign LEDn = led_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
